// File: rtl/bus_initiator_pkg.sv
// Shared types and constants for the bus initiator.
// Optional watchdog is enabled by defining BUS_INITIATOR_TIMEOUT_EN.
package bus_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/bus_initiator_wdog.sv
// Acknowledge watchdog: counts cycles while enabled; expired is high during
// the TIMEOUT-th enabled cycle so the FSM can abort at the end of it.
module bus_initiator_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  assign expired = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (enable && !expired)  cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding command-to-bus initiator (IDLE/REQ/RESP), registered outputs.
// Define BUS_INITIATOR_TIMEOUT_EN to add the acknowledge watchdog.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rw,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W/8-1:0] cmd_byte_enable,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic [ADDR_W-1:0]   address,
  output logic                bus_enable,
  output logic [DATA_W/8-1:0] byte_enable,
  output logic                rw,
  output logic [DATA_W-1:0]   write_data,
  input  logic                acknowledge,
  input  logic [DATA_W-1:0]   read_data
);

  localparam int BE_W = DATA_W / 8;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT must be in 1..255");
  end

  state_t state, state_next;
  logic   expired;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  bus_initiator_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .clear   (state != REQ),
    .enable  (state == REQ),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  logic              cmd_ready_d, bus_enable_d, rsp_valid_d, rw_d, rsp_error_d;
  logic [ADDR_W-1:0] address_d;
  logic [BE_W-1:0]   byte_enable_d;
  logic [DATA_W-1:0] write_data_d, rsp_data_d;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_valid && cmd_ready)     state_next = REQ;
      REQ:     if (acknowledge || expired)     state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready)     state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
  end

  // Next values of the output registers; the bus is parked as an idle read
  // whenever the next state is not REQ.
  always_comb begin
    cmd_ready_d   = (state_next == IDLE);
    bus_enable_d  = (state_next == REQ);
    rsp_valid_d   = (state_next == RESP);
    address_d     = '0;
    byte_enable_d = '0;
    rw_d          = RW_READ;
    write_data_d  = '0;
    rsp_data_d    = '0;
    rsp_error_d   = 1'b0;
    if (state_next == REQ) begin
      if (state == IDLE) begin
        address_d     = cmd_address;
        byte_enable_d = cmd_byte_enable;
        rw_d          = cmd_rw;
        write_data_d  = cmd_wdata;
      end else begin
        address_d     = address;
        byte_enable_d = byte_enable;
        rw_d          = rw;
        write_data_d  = write_data;
      end
    end
    if (state == REQ && state_next == RESP) begin
      // Ack wins over a simultaneous watchdog expiry.
      rsp_data_d = (acknowledge && rw == RW_READ) ? read_data : '0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      rsp_error_d = !acknowledge;
`endif
    end else if (state == RESP && state_next == RESP) begin
      rsp_data_d  = rsp_data;
      rsp_error_d = rsp_error;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_ready   <= 1'b0;
      bus_enable  <= 1'b0;
      rsp_valid   <= 1'b0;
      address     <= '0;
      byte_enable <= '0;
      rw          <= RW_READ;
      write_data  <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      bus_enable  <= bus_enable_d;
      rsp_valid   <= rsp_valid_d;
      address     <= address_d;
      byte_enable <= byte_enable_d;
      rw          <= rw_d;
      write_data  <= write_data_d;
      rsp_data    <= rsp_data_d;
      rsp_error   <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator; watchdog scenarios run when
// BUS_INITIATOR_TIMEOUT_EN is defined (DUT built with TIMEOUT=4).
module tb_bus_initiator;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [18:0] cmd_address;
  logic [1:0]  cmd_byte_enable;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [15:0] rsp_data;
  logic [18:0] address;
  logic        bus_enable, rw;
  logic [1:0]  byte_enable;
  logic [15:0] write_data;
  logic        acknowledge;
  logic [15:0] read_data;

  int checks = 0;
  int errors = 0;

  bus_initiator #(.ADDR_W(19), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .address(address), .bus_enable(bus_enable), .byte_enable(byte_enable), .rw(rw),
    .write_data(write_data), .acknowledge(acknowledge), .read_data(read_data)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk); #1;
  endtask

  // Offer a command once cmd_ready is up; returns in the first REQ cycle.
  task automatic issue(input logic r, input logic [18:0] a, input logic [1:0] be,
                       input logic [15:0] wd);
    int n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL issue_wait cmd_ready got %b exp 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_rw = r; cmd_address = a; cmd_byte_enable = be; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (bus_enable !== 1'b0) begin errors++; $display("FAIL rst_bus_enable got %b exp 0", bus_enable); end
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rst_rw got %b exp 1", rw); end
    checks++; if (address !== 19'h0) begin errors++; $display("FAIL rst_address got %h exp 0", address); end
    checks++; if (byte_enable !== 2'b00) begin errors++; $display("FAIL rst_byte_enable got %b exp 00", byte_enable); end
    checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL rst_write_data got %h exp 0", write_data); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_error got %b exp 0", rsp_error); end
    reset_reset = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    issue(1'b0, 19'h00012, 2'b11, 16'hBEEF);
    checks++; if (bus_enable !== 1'b1) begin errors++; $display("FAIL wr_bus_enable got %b exp 1", bus_enable); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL wr_rw got %b exp 0", rw); end
    checks++; if (address !== 19'h00012) begin errors++; $display("FAIL wr_address got %h exp 00012", address); end
    checks++; if (write_data !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata got %h exp beef", write_data); end
    checks++; if (byte_enable !== 2'b11) begin errors++; $display("FAIL wr_be got %b exp 11", byte_enable); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_early_rsp got %b exp 0", rsp_valid); end
    acknowledge = 1'b1; read_data = 16'h5555;
    tick();
    acknowledge = 1'b0;
    checks++; if (bus_enable !== 1'b0) begin errors++; $display("FAIL wr_be_drop got %b exp 0", bus_enable); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL wr_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL wr_rsp_error got %b exp 0", rsp_error); end
    checks++; if (rw !== 1'b1 || write_data !== 16'h0) begin errors++; $display("FAIL wr_park got rw %b wd %h exp 1 0", rw, write_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_done got %b exp 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_again got %b exp 1", cmd_ready); end
  endtask

  task automatic test_read_stall();
    issue(1'b1, 19'h7FFFF, 2'b01, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_enable !== 1'b1 || address !== 19'h7FFFF || byte_enable !== 2'b01 ||
                    rw !== 1'b1 || write_data !== 16'h1234)
        begin errors++; $display("FAIL rd_hold[%0d] got be %b a %h ben %b rw %b wd %h", i, bus_enable, address, byte_enable, rw, write_data); end
      if (i == 3) begin acknowledge = 1'b1; read_data = 16'h00A5; end
      tick();
      acknowledge = 1'b0;
    end
    // Stray acknowledge in RESP must not disturb the held response.
    acknowledge = 1'b1; read_data = 16'hFFFF;
    for (int j = 0; j < 5; j++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h00A5 || rsp_error !== 1'b0 ||
                    cmd_ready !== 1'b0 || bus_enable !== 1'b0)
        begin errors++; $display("FAIL rd_stall[%0d] got v %b d %h e %b rdy %b ben %b", j, rsp_valid, rsp_data, rsp_error, cmd_ready, bus_enable); end
      tick();
    end
    acknowledge = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_release got v %b rdy %b exp 0 1", rsp_valid, cmd_ready); end
    // Zero byte-enable write accepted immediately and issued unchanged.
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_address = 19'h00100; cmd_byte_enable = 2'b00; cmd_wdata = 16'h0F0F;
    tick();
    cmd_valid = 1'b0;
    checks++; if (bus_enable !== 1'b1 || byte_enable !== 2'b00 || rw !== 1'b0 || write_data !== 16'h0F0F)
      begin errors++; $display("FAIL be0_issue got ben %b be %b rw %b wd %h", bus_enable, byte_enable, rw, write_data); end
    acknowledge = 1'b1;
    tick();
    acknowledge = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0) begin errors++; $display("FAIL be0_rsp got v %b d %h exp 1 0", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    rsp_ready = 1'b1; acknowledge = 1'b1; read_data = 16'h1234;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_address = 19'h00003; cmd_byte_enable = 2'b11; cmd_wdata = 16'h0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (rsp_valid) begin
        n++;
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL b2b_data got %h exp 1234", rsp_data); end
      end
    end
    cmd_valid = 1'b0; acknowledge = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
    tick();
    rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || bus_enable !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy %b ben %b", cmd_ready, bus_enable); end
  endtask

`ifdef BUS_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    read_data = 16'hFFFF;
    issue(1'b1, 19'h00040, 2'b11, 16'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_enable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_req[%0d] got ben %b v %b", i, bus_enable, rsp_valid); end
      tick();
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 16'h0 || bus_enable !== 1'b0)
      begin errors++; $display("FAIL to_abort got v %b e %b d %h ben %b exp 1 1 0 0", rsp_valid, rsp_error, rsp_data, bus_enable); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    issue(1'b1, 19'h00040, 2'b11, 16'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) acknowledge = 1'b1;
      tick();
      acknowledge = 1'b0;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_data !== 16'hFFFF)
      begin errors++; $display("FAIL to_ack_wins got v %b e %b d %h exp 1 0 ffff", rsp_valid, rsp_error, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`else
  task automatic test_no_watchdog();
    issue(1'b1, 19'h00040, 2'b11, 16'h0);
    repeat (20) tick();
    checks++; if (bus_enable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL nowd_wait got ben %b v %b exp 1 0", bus_enable, rsp_valid); end
    acknowledge = 1'b1; read_data = 16'hCAFE;
    tick();
    acknowledge = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_data !== 16'hCAFE)
      begin errors++; $display("FAIL nowd_rsp got v %b e %b d %h exp 1 0 cafe", rsp_valid, rsp_error, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    issue(1'b0, 19'h00055, 2'b11, 16'hAAAA);
    tick();
    reset_reset = 1'b1;
    #1;
    checks++; if (bus_enable !== 1'b0) begin errors++; $display("FAIL mid_bus_enable got %b exp 0", bus_enable); end
    checks++; if (rw !== 1'b1 || write_data !== 16'h0) begin errors++; $display("FAIL mid_park got rw %b wd %h exp 1 0", rw, write_data); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_hs got v %b rdy %b exp 0 0", rsp_valid, cmd_ready); end
    tick();
    reset_reset = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", cmd_ready); end
    repeat (3) tick();
    checks++; if (rsp_valid !== 1'b0 || bus_enable !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got v %b ben %b exp 0 0", rsp_valid, bus_enable); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1);
  end

  initial begin
    reset_reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_address = '0;
    cmd_byte_enable = '0; cmd_wdata = '0; rsp_ready = 1'b0; acknowledge = 1'b0; read_data = '0;
    tick(); tick();
    test_reset();
    test_write();
    test_read_stall();
    test_back_to_back();
`ifdef BUS_INITIATOR_TIMEOUT_EN
    test_timeout();
`else
    test_no_watchdog();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
